serial_addsub: RTL and testbench
================================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH), bit-index counter width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  request to begin an operation.
REQ-006 The block SHALL have port mode  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-007 The block SHALL have ports a, b  input  WIDTH  unsigned operands.
REQ-008 The block SHALL have port busy  output  1  high while bits are being processed.
REQ-009 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 The block SHALL have port result  output  WIDTH  sum or difference, held until the next accepted start.
REQ-011 The block SHALL have port flag  output  1  add: carry-out; subtract: borrow-out (1 when a<b unsigned).
REQ-012 Clocking SHALL be one clock; reset SHALL be synchronous and active-high.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DONE.
REQ-014 In IDLE or DONE, start=1 at an edge SHALL capture a, b and mode, clear the bit index to 0, load the carry with mode, and enter RUN.
REQ-015 Start while in RUN SHALL be ignored; captured operands SHALL NOT change.
REQ-016 In RUN, each cycle SHALL process exactly one bit, LSB first: sum bit = a[i] ^ b'[i] ^ c, with b' = b (add) or ~b (subtract).
REQ-017 The next carry SHALL be the majority of a[i], b'[i] and c; the sum bit SHALL be shifted into result from the MSB end.
REQ-018 After WIDTH RUN cycles (index = WIDTH-1 processed), the FSM SHALL enter DONE.
REQ-019 On DONE entry, flag SHALL be set to the final carry for add, and to the inverted final carry for subtract.
REQ-020 Latency: with start accepted at edge k, busy SHALL be 1 for cycles k+1..k+WIDTH, and done SHALL be 1 only in cycle k+WIDTH+1.
REQ-021 DONE SHALL last one cycle, then go to IDLE unless start=1, in which case it goes to RUN per REQ-014.
REQ-022 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-023 Result and flag SHALL be modulo 2^WIDTH and SHALL be valid from the done cycle until the next accepted start.
REQ-024 During RUN, result SHALL hold partial shift contents that are not meaningful.

Reset
REQ-025 Reset SHALL force state IDLE, busy=0, done=0, result=0, flag=0, index=0 and carry=0 at the next edge, including mid-RUN; a start coincident with reset SHALL be dropped.

Configuration
REQ-026 With SERIAL_ADDSUB_OVF_EN defined, the block SHALL add output port ovf  output  1, giving signed two's-complement overflow (carry into MSB xor carry out of MSB), updated with flag and reset to 0.
REQ-027 Without SERIAL_ADDSUB_OVF_EN, port ovf and its logic SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-028 Package addsub_pkg SHALL hold the state enum typedef (addsub_state_t) and the constants MODE_ADD=1'b0 and MODE_SUB=1'b1.
REQ-029 One combinational sub-module, addsub_bit (inputs a, b, cin, sub; outputs s, cout), SHALL implement the per-bit cell and be instantiated once.

Verification (WIDTH=8)
REQ-030 Sub 5-3: start with a=5, b=3, mode=1 -> busy for 8 cycles, done in cycle 9, result=0x02, flag=0.
REQ-031 Sub 3-5: a=3, b=5, mode=1 -> result=0xFE, flag=1; with OVF_EN, ovf=0.
REQ-032 Add 200+100: a=200, b=100, mode=0 -> result=0x2C, flag=1; a start pulse applied in cycle 4 is ignored and the result is unchanged.
REQ-033 Reset mid-run: assert reset in cycle 4 of RUN -> the next cycle shows busy=0, done=0, result=0, and no done pulse follows.
REQ-034 Back-to-back: start held high through DONE -> a second operation (a=0x80, b=0x01, sub) starts with no IDLE cycle, giving result=0x7F, flag=0, and ovf=1 when OVF_EN is defined.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } addsub_state_t;

endpackage

// File: rtl/addsub_bit.sv
// One-bit add/subtract cell: b is inverted when sub=1, carry-in supplies the +1.
module addsub_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic sub,
    output logic s,
    output logic cout
);

    logic bx;

    assign bx   = b ^ sub;
    assign s    = a ^ bx ^ cin;
    assign cout = (a & bx) | (a & cin) | (bx & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first, one bit per cycle.
// Define SERIAL_ADDSUB_OVF_EN to add the signed-overflow output ovf.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADDSUB_OVF_EN
    output logic             ovf,
`endif
    output logic             flag
);

    addsub_state_t    state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_q, flag_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic bit_s;
    logic bit_cout;

    addsub_bit u_bit (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (carry_q),
        .sub  (mode_q),
        .s    (bit_s),
        .cout (bit_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
        flag_d   = flag_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    idx_d   = '0;
                    carry_d = mode;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                result_d = {bit_s, result_q[WIDTH-1:1]};
                carry_d  = bit_cout;
                idx_d    = idx_q + CNT_W'(1);
                if (idx_q == CNT_W'(WIDTH - 1)) begin
                    // Subtract reports borrow, i.e. the complement of the carry.
                    flag_d  = (mode_q == MODE_SUB) ? ~bit_cout : bit_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
                    ovf_d   = carry_q ^ bit_cout;
`endif
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= MODE_ADD;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            flag_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign flag   = flag_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Directed plus random checks of serial_addsub (WIDTH=8) against an arithmetic model.
module tb_serial_addsub;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             flag;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf;
`endif

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_result;
    logic             exp_flag;
    logic             exp_ovf;

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
`ifdef SERIAL_ADDSUB_OVF_EN
        .ovf    (ovf),
`endif
        .flag   (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Plain-arithmetic reference: full-width sum/difference and signed overflow.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mm);
        int unsigned ua;
        int unsigned ub;
        int unsigned full;
        ua = int'(ma);
        ub = int'(mb);
        if (mm) begin
            full     = (ua - ub) & 32'h1FF;
            exp_flag = (ua < ub);
            exp_ovf  = (ma[WIDTH-1] != mb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
        end else begin
            full     = ua + ub;
            exp_flag = (full >= (1 << WIDTH));
            exp_ovf  = (ma[WIDTH-1] == mb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
        end
        exp_result = full[WIDTH-1:0];
    endtask

    // Drive start for one edge; on return we are in the first RUN cycle.
    task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tm);
        a     = ta;
        b     = tb;
        mode  = tm;
        start = 1'b1;
        model(ta, tb, tm);
        tick();
        start = 1'b0;
    endtask

    // Walk the RUN cycles, optionally poking a stray start at RUN cycle 4; stop in the done cycle.
    task automatic run_to_done(input string tag, input bit inject);
        for (int i = 1; i <= int'(WIDTH); i++) begin
            check({tag, ".busy"}, 32'(busy), 32'd1);
            check({tag, ".done_low"}, 32'(done), 32'd0);
            if (inject && i == 4) begin
                a     = 8'hFF;
                b     = 8'hFF;
                mode  = ~mode;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".busy_low"}, 32'(busy), 32'd0);
        check({tag, ".result"}, 32'(result), 32'(exp_result));
        check({tag, ".flag"}, 32'(flag), 32'(exp_flag));
`ifdef SERIAL_ADDSUB_OVF_EN
        check({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
    endtask

    task automatic after_done(input string tag);
        tick();
        check({tag, ".idle_done"}, 32'(done), 32'd0);
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check({tag, ".hold_result"}, 32'(result), 32'(exp_result));
        check({tag, ".hold_flag"}, 32'(flag), 32'(exp_flag));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.result", 32'(result), 32'd0);
        check("reset.flag", 32'(flag), 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("reset.ovf", 32'(ovf), 32'd0);
`endif
        reset = 1'b0;
        tick();

        // Known vectors
        start_op(8'd5, 8'd3, 1'b1);
        check("sub53.exp_const", 32'(exp_result), 32'h02);
        run_to_done("sub53", 1'b0);
        after_done("sub53");

        start_op(8'd3, 8'd5, 1'b1);
        run_to_done("sub35", 1'b0);
        check("sub35.result_const", 32'(result), 32'hFE);
        check("sub35.flag_const", 32'(flag), 32'd1);
        after_done("sub35");

        start_op(8'd200, 8'd100, 1'b0);
        run_to_done("add200", 1'b1);
        check("add200.result_const", 32'(result), 32'h2C);
        after_done("add200");

        // Reset in the fourth RUN cycle
        start_op(8'd77, 8'd11, 1'b0);
        tick();
        tick();
        tick();
        check("rst_mid.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid.busy", 32'(busy), 32'd0);
        check("rst_mid.done", 32'(done), 32'd0);
        check("rst_mid.result", 32'(result), 32'd0);
        check("rst_mid.flag", 32'(flag), 32'd0);
        for (int i = 0; i < int'(WIDTH) + 2; i++) begin
            tick();
            check("rst_mid.no_done", 32'(done), 32'd0);
        end

        // Start coincident with reset is dropped
        a     = 8'h12;
        b     = 8'h34;
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rst_start.busy0", 32'(busy), 32'd0);
        tick();
        check("rst_start.busy1", 32'(busy), 32'd0);

        // Back-to-back: start held through DONE, no IDLE gap
        start_op(8'h10, 8'h20, 1'b0);
        run_to_done("b2b_first", 1'b0);
        start_op(8'h80, 8'h01, 1'b1);
        run_to_done("b2b_second", 1'b0);
        check("b2b_second.result_const", 32'(result), 32'h7F);
        check("b2b_second.flag_const", 32'(flag), 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("b2b_second.ovf_const", 32'(ovf), 32'd1);
`endif
        after_done("b2b_second");

        // Random operations, some chained back-to-back
        for (int n = 0; n < 24; n++) begin
            start_op(8'($urandom), 8'($urandom), 1'($urandom));
            run_to_done($sformatf("rnd%0d", n), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) != 0) begin
                after_done($sformatf("rnd%0d", n));
            end
        end
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
